// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply base^exponent mod modulus over one external Mult; every product reduced in 2*WIDTH cycles.
// start is ignored while busy; Mult latency is absorbed in the *_WAIT states. Define CONST_TIME_EN to run a multiply step on every exponent bit.
module modexp_ctrl #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       base,
  input  logic [EXP_WIDTH-1:0]   exponent,
  input  logic [WIDTH-1:0]       modulus,
  output logic                   mult_start,
  output logic [WIDTH-1:0]       mult_in1,
  output logic [WIDTH-1:0]       mult_in2,
  input  logic [2*WIDTH-1:0]     mult_out,
  input  logic                   mult_finish,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   finish,
  output logic [4:0]             mult_ops
);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int CW = $clog2(2*WIDTH);

  typedef enum logic [3:0] {
    S_IDLE, S_BRED, S_SQ_REQ, S_SQ_WAIT, S_SQ_RED,
    S_MUL_REQ, S_MUL_WAIT, S_MUL_RED, S_NEXT, S_DONE
  } state_t;

  state_t               r_state, w_nxt;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_mod, r_r, r_b, r_result;
  logic [IW-1:0]        r_i;
  logic [2*WIDTH-1:0]   r_dvd;
  logic [WIDTH:0]       r_rem;
  logic [CW-1:0]        r_cnt;
  logic [4:0]           r_ops;
  logic [WIDTH+1:0]     w_rem_sh;
  logic [WIDTH:0]       w_rem_nxt;
  logic                 w_ge, w_red_last, w_bit;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh   = {r_rem, r_dvd[2*WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {2'b00, r_mod});
  assign w_rem_nxt  = w_ge ? (WIDTH+1)'(w_rem_sh - {2'b00, r_mod}) : w_rem_sh[WIDTH:0];
  assign w_red_last = (r_cnt == CW'(2*WIDTH-1));
  assign w_bit      = r_exp[r_i];
  assign result     = r_result;
  assign mult_ops   = r_ops;

  always_comb begin
    w_nxt      = r_state;
    mult_start = 1'b0;
    mult_in1   = '0;
    mult_in2   = '0;
    busy       = (r_state != S_IDLE);
    finish     = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_nxt = (modulus <= WIDTH'(1)) ? S_DONE : S_BRED;
      S_BRED:     if (w_red_last) w_nxt = S_SQ_REQ;
      S_SQ_REQ: begin
        mult_start = 1'b1;
        mult_in1   = r_r;
        mult_in2   = r_r;
        w_nxt      = S_SQ_WAIT;
      end
      S_SQ_WAIT:  if (mult_finish) w_nxt = S_SQ_RED;
      S_SQ_RED: begin
`ifdef CONST_TIME_EN
        if (w_red_last) w_nxt = S_MUL_REQ;
`else
        if (w_red_last) w_nxt = w_bit ? S_MUL_REQ : S_NEXT;
`endif
      end
      S_MUL_REQ: begin
        mult_start = 1'b1;
        mult_in1   = r_r;
        mult_in2   = r_b;
        w_nxt      = S_MUL_WAIT;
      end
      S_MUL_WAIT: if (mult_finish) w_nxt = S_MUL_RED;
      S_MUL_RED:  if (w_red_last) w_nxt = S_NEXT;
      S_NEXT:     w_nxt = (r_i == '0) ? S_DONE : S_SQ_REQ;
      S_DONE: begin
        finish = 1'b1;
        w_nxt  = S_IDLE;
      end
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_exp    <= '0;
      r_mod    <= '0;
      r_r      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_i      <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_ops    <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_exp <= exponent;
          r_mod <= modulus;
          r_ops <= '0;
          r_i   <= IW'(EXP_WIDTH-1);
          r_dvd <= {{WIDTH{1'b0}}, base};
          r_rem <= '0;
          r_cnt <= '0;
          if (modulus <= WIDTH'(1)) begin
            r_r      <= '0;
            r_result <= '0;
          end else begin
            r_r <= WIDTH'(1);
          end
        end
        S_SQ_REQ, S_MUL_REQ: r_ops <= (r_ops == 5'd31) ? r_ops : r_ops + 5'd1;
        S_SQ_WAIT, S_MUL_WAIT: if (mult_finish) begin
          r_dvd <= mult_out;
          r_rem <= '0;
          r_cnt <= '0;
        end
        S_BRED, S_SQ_RED, S_MUL_RED: begin
          r_dvd <= r_dvd << 1;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_red_last) begin
            if (r_state == S_BRED)        r_b <= w_rem_nxt[WIDTH-1:0];
            else if (r_state == S_SQ_RED) r_r <= w_rem_nxt[WIDTH-1:0];
`ifdef CONST_TIME_EN
            else if (w_bit)               r_r <= w_rem_nxt[WIDTH-1:0];
`else
            else                          r_r <= w_rem_nxt[WIDTH-1:0];
`endif
          end
        end
        S_NEXT: begin
          if (r_i == '0) r_result <= r_r;
          else           r_i      <= r_i - IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Left-to-right square-and-multiply scheduler that computes base^exponent mod modulus. It sequences one external Mult unit through the Mult start/finish handshake. It reduces each 16-bit product with an internal bit-serial restoring remainder unit. It is the top-level exponentiation engine for the RSA timing side-channel experiments and exposes a multiply-operation count for leakage analysis.

Parameters:
WIDTH, 8, operand/modulus width; must equal the Mult in1/in2 width (product is 2*WIDTH)
EXP_WIDTH, 8, exponent width; number of square-and-multiply iterations

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  1-cycle request; base/exponent/modulus sampled when start=1 and busy=0
base  input  WIDTH  base operand
exponent  input  EXP_WIDTH  exponent
modulus  input  WIDTH  modulus
mult_start  output  1  1-cycle pulse to Mult; mult_in1/mult_in2 valid in the same cycle
mult_in1  output  WIDTH  Mult operand A
mult_in2  output  WIDTH  Mult operand B
mult_out  input  2*WIDTH  Mult product
mult_finish  input  1  Mult completion pulse; mult_out valid in the same cycle
result  output  WIDTH  base^exponent mod modulus; held until the next accepted start
busy  output  1  high from the cycle after start is accepted until finish
finish  output  1  1-cycle done pulse
mult_ops  output  5  Mult invocations in the last or current operation (squares + multiplies)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result=0, busy=0, finish=0, mult_start=0, mult_in1=0, mult_in2=0, mult_ops=0. Reset mid-operation aborts the operation immediately with no finish pulse. The Mult unit shares the same reset.
- start while busy=1: ignored.
- States:
  - IDLE: on start, latch the inputs, set mult_ops=0 and r=1.
    - If modulus<=1: go to DONE with r=0.
    - Otherwise go to BRED.
  - BRED: reduce {0,base} mod modulus into b_red using the remainder unit.
  - SQ_REQ: mult_in1=mult_in2=r; pulse mult_start; mult_ops+1; go to SQ_WAIT.
  - SQ_WAIT: hold until mult_finish; capture mult_out; go to SQ_RED.
  - SQ_RED: r = product mod modulus.
    - If exponent bit i=1: go to MUL_REQ.
    - Otherwise go to NEXT.
  - MUL_REQ / MUL_WAIT / MUL_RED: same sequence as the square states with operands r and b_red.
  - NEXT: if i==0 go to DONE; otherwise i-1 and go to SQ_REQ. i starts at EXP_WIDTH-1.
  - DONE: result = r mod modulus (r=1 already satisfies this since modulus>=2); finish=1 for one cycle; go to IDLE.
- All EXP_WIDTH bits are processed, including leading zeros (squaring r=1 is harmless).
- exponent=0: result=1 (modulus>=2).
- Remainder unit:
  - Restoring division of a 2*WIDTH dividend by modulus, one quotient bit per cycle.
  - Exactly 2*WIDTH cycles per reduction, independent of the data values.
  - The partial remainder is held at WIDTH+1 bits to avoid overflow before the compare/subtract.
- mult_start is never asserted outside the *_REQ states. At most one Mult operation is outstanding at a time.
- A mult_finish that arrives outside a *_WAIT state is ignored.
- mult_ops saturates at 31.

Optional Feature:
CONST_TIME_EN: when defined, MUL_REQ/MUL_WAIT/MUL_RED run for every exponent bit. When the bit is 0, the product is computed but discarded, so r is unchanged. This gives mult_ops=2*EXP_WIDTH and a data-independent cycle count. When the macro is undefined, the multiply step runs only for 1-bits: mult_ops = EXP_WIDTH + popcount(exponent), and timing leaks the exponent Hamming weight.

Test Plan:
- base=4, exponent=13, modulus=97, Mult model with 3-cycle latency -> result=93, one finish pulse, mult_ops=11 (16 with CONST_TIME_EN).
- base=200, exponent=1, modulus=13 -> result=5; base=7, exponent=0, modulus=13 -> result=1, mult_ops=8.
- modulus=1 or modulus=0, any base/exponent -> result=0, finish within 3 cycles of start, mult_ops=0, mult_start never asserted.
- Timing: exponent=0x80 vs exponent=0xFF, base=3, modulus=251 -> without CONST_TIME_EN, cycle counts differ by 7 multiply steps; with CONST_TIME_EN, cycle counts are identical and results are correct for both.
- start pulsed again while busy -> ignored, first result unaffected; start on the cycle after finish -> accepted.
- rst=1 asserted during SQ_WAIT -> next cycle busy=0, result=0, mult_start=0, no finish; a new start then gives the correct result.
